// File: rtl/lanes_pattern_checker.sv
// Multi-lane incrementing-pattern checker with per-lane lock tracking,
// saturating error counters and a two-cycle command/register interface.
module lanes_pattern_checker #(
  parameter int g_NumberOfLanes = 6,
  parameter int g_WidthADDR     = 8,
  parameter int g_WidthDATA     = 16
) (
  input  logic                         Clock,
  input  logic                         Reset_N,
  input  logic [64*g_NumberOfLanes-1:0] Data_In,
  input  logic                         Data_Valid,
  input  logic                         enable_cmd,
  input  logic                         write_read,
  input  logic [g_WidthADDR-1:0]       addr_frame,
  input  logic [g_WidthDATA-1:0]       write_data_frame,
  output logic                         busy,
  output logic [g_WidthDATA-1:0]       read_data_frame,
  output logic [g_NumberOfLanes-1:0]   Lane_Locked,
  output logic [g_NumberOfLanes-1:0]   Lane_Error,
  output logic                         Error_Flag
);

  typedef enum logic [1:0] {
    CMD_IDLE,
    CMD_BUSY1,
    CMD_BUSY2
  } cmd_state_t;

  typedef enum logic {
    LANE_UNLOCKED,
    LANE_LOCKED
  } lane_state_t;

  // Command path state
  cmd_state_t             cmd_state_reg, cmd_state_next;
  logic                   cmd_wr_reg;
  logic [g_WidthADDR-1:0] cmd_addr_reg;
  logic [1:0]             cmd_wdata_reg;

  // Control / status registers
  logic                   enable_reg;
  logic                   error_flag_reg;
  logic [31:0]            word_cnt_reg;
  logic [31:0]            word_snap_reg;
  logic [g_WidthDATA-1:0] read_data_reg;

  // Decoded strobes
  logic                   wr_strobe;
  logic                   rd_strobe;
  logic                   ctrl_wr;
  logic                   clear_req;
  logic [15:0]            rd_value;

  // Per-lane shared views
  logic [g_NumberOfLanes-1:0] lane_mismatch;
  logic [g_NumberOfLanes-1:0] lane_locked_vec;
  logic [g_NumberOfLanes-1:0] lane_error_vec;
  logic [15:0]                err_cnt [g_NumberOfLanes];

  logic unused_wdata_bits;
  assign unused_wdata_bits = ^write_data_frame;

  // ---------------------------------------------------------------------------
  // Command handshake FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (!Reset_N) begin
      cmd_state_reg <= CMD_IDLE;
      cmd_wr_reg    <= 1'b0;
      cmd_addr_reg  <= '0;
      cmd_wdata_reg <= '0;
    end else begin
      cmd_state_reg <= cmd_state_next;
      if (cmd_state_reg == CMD_IDLE && enable_cmd) begin
        cmd_wr_reg    <= write_read;
        cmd_addr_reg  <= addr_frame;
        cmd_wdata_reg <= write_data_frame[1:0];
      end
    end
  end

  always_comb begin
    cmd_state_next = cmd_state_reg;
    case (cmd_state_reg)
      CMD_IDLE:  if (enable_cmd) cmd_state_next = CMD_BUSY1;
      CMD_BUSY1: cmd_state_next = CMD_BUSY2;
      CMD_BUSY2: cmd_state_next = CMD_IDLE;
      default:   cmd_state_next = CMD_IDLE;
    endcase
  end

  assign busy      = (cmd_state_reg != CMD_IDLE);
  assign wr_strobe = (cmd_state_reg == CMD_BUSY1) && cmd_wr_reg;
  assign rd_strobe = (cmd_state_reg == CMD_BUSY2) && !cmd_wr_reg;
  assign ctrl_wr   = wr_strobe && (cmd_addr_reg == '0);
  assign clear_req = ctrl_wr && cmd_wdata_reg[1];

  // ---------------------------------------------------------------------------
  // Register read mux; unmapped addresses fall through to zero
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_value = 16'h0000;
    if (cmd_addr_reg == g_WidthADDR'(0)) begin
      rd_value[0] = enable_reg;
    end else if (cmd_addr_reg == g_WidthADDR'(1)) begin
      for (int n = 0; n < g_NumberOfLanes && n < 15; n++) begin
        rd_value[n] = lane_locked_vec[n];
      end
      rd_value[15] = error_flag_reg;
    end else if (cmd_addr_reg == g_WidthADDR'(2)) begin
      rd_value = word_cnt_reg[15:0];
    end else if (cmd_addr_reg == g_WidthADDR'(3)) begin
      rd_value = word_snap_reg[31:16];
    end else begin
      for (int n = 0; n < g_NumberOfLanes; n++) begin
        if (cmd_addr_reg == g_WidthADDR'(16 + n)) begin
          rd_value = err_cnt[n];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control, global counters and read-back registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (!Reset_N) begin
      enable_reg     <= 1'b0;
      error_flag_reg <= 1'b0;
      word_cnt_reg   <= '0;
      word_snap_reg  <= '0;
      read_data_reg  <= '0;
    end else begin
      if (ctrl_wr) begin
        enable_reg <= cmd_wdata_reg[0];
      end

      // Clear has priority over any increment landing on the same edge
      if (clear_req) begin
        error_flag_reg <= 1'b0;
      end else if (|lane_mismatch) begin
        error_flag_reg <= 1'b1;
      end

      if (clear_req) begin
        word_cnt_reg <= '0;
      end else if (enable_reg && Data_Valid) begin
        word_cnt_reg <= word_cnt_reg + 32'd1;
      end

      // Reading the low half captures all 32 bits so the high half matches
      if (rd_strobe && cmd_addr_reg == g_WidthADDR'(2)) begin
        word_snap_reg <= word_cnt_reg;
      end

      if (rd_strobe) begin
        read_data_reg <= g_WidthDATA'(rd_value);
      end
    end
  end

  assign read_data_frame = read_data_reg;
  assign Error_Flag      = error_flag_reg;
  assign Lane_Locked     = lane_locked_vec;
  assign Lane_Error      = lane_error_vec;

  // ---------------------------------------------------------------------------
  // Per-lane pattern checkers
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < g_NumberOfLanes; gi++) begin : g_lane
      logic [15:0] s0, s1, s2, s3;
      logic        consecutive;
      logic        match;
      logic        mismatch;

      lane_state_t lane_state_reg, lane_state_next;
      logic [15:0] expect_reg, expect_next;
      logic [1:0]  miss_reg, miss_next;
      logic [15:0] err_cnt_reg;
      logic        lane_err_reg;

      assign s0 = Data_In[64*gi +  0 +: 16];
      assign s1 = Data_In[64*gi + 16 +: 16];
      assign s2 = Data_In[64*gi + 32 +: 16];
      assign s3 = Data_In[64*gi + 48 +: 16];

      assign consecutive = (s1 == s0 + 16'd1) && (s2 == s0 + 16'd2) &&
                           (s3 == s0 + 16'd3);
      assign match = (s0 == expect_reg) && (s1 == expect_reg + 16'd1) &&
                     (s2 == expect_reg + 16'd2) && (s3 == expect_reg + 16'd3);

      always_comb begin
        lane_state_next = lane_state_reg;
        expect_next     = expect_reg;
        miss_next       = miss_reg;
        mismatch        = 1'b0;
        if (!enable_reg) begin
          lane_state_next = LANE_UNLOCKED;
          miss_next       = 2'd0;
        end else if (Data_Valid) begin
          case (lane_state_reg)
            LANE_UNLOCKED: begin
              if (consecutive) begin
                lane_state_next = LANE_LOCKED;
                expect_next     = s3 + 16'd1;
                miss_next       = 2'd0;
              end
            end
            LANE_LOCKED: begin
              if (match) begin
                expect_next = expect_reg + 16'd4;
                miss_next   = 2'd0;
              end else begin
                mismatch    = 1'b1;
                expect_next = s3 + 16'd1;
                // Three earlier misses in a row means this one drops lock
                if (miss_reg == 2'd3) begin
                  lane_state_next = LANE_UNLOCKED;
                  miss_next       = 2'd0;
                end else begin
                  miss_next = miss_reg + 2'd1;
                end
              end
            end
            default: lane_state_next = LANE_UNLOCKED;
          endcase
        end
      end

      always_ff @(posedge Clock) begin
        if (!Reset_N) begin
          lane_state_reg <= LANE_UNLOCKED;
          expect_reg     <= '0;
          miss_reg       <= '0;
          err_cnt_reg    <= '0;
          lane_err_reg   <= 1'b0;
        end else begin
          lane_state_reg <= lane_state_next;
          expect_reg     <= expect_next;
          miss_reg       <= miss_next;
          lane_err_reg   <= mismatch;
          if (clear_req) begin
            err_cnt_reg <= '0;
          end else if (mismatch && err_cnt_reg != 16'hFFFF) begin
            err_cnt_reg <= err_cnt_reg + 16'd1;
          end
        end
      end

      assign lane_mismatch[gi]   = mismatch;
      assign lane_locked_vec[gi] = (lane_state_reg == LANE_LOCKED);
      assign lane_error_vec[gi]  = lane_err_reg;
      assign err_cnt[gi]         = err_cnt_reg;
    end
  endgenerate

endmodule

// File: doc/lanes_pattern_checker.md
LANES_PATTERN_CHECKER -- requirements
Module: lanes_pattern_checker

Interface
REQ-001 SHALL have parameter g_NumberOfLanes, default 6, number of 64-bit receive lanes.
REQ-002 SHALL have parameter g_WidthADDR, default 8, control bus address width.
REQ-003 SHALL have parameter g_WidthDATA, default 16, control bus data width.
REQ-004 SHALL use one clock and a synchronous, active-low reset; there is no other clock or reset.
REQ-005 SHALL have port Clock  in  1  the single clock; all logic is rising-edge.
REQ-006 SHALL have port Reset_N  in  1  synchronous active-low reset.
REQ-007 SHALL have port Data_In  in  64*g_NumberOfLanes  received lane data; lane n = [64n+63:64n], sample k = [64n+16k+15:64n+16k].
REQ-008 SHALL have port Data_Valid  in  1  Data_In qualifier, one word per lane per high cycle.
REQ-009 SHALL have port enable_cmd  in  1  one-cycle control bus command strobe.
REQ-010 SHALL have port write_read  in  1  1 = write, 0 = read; sampled with enable_cmd.
REQ-011 SHALL have port addr_frame  in  g_WidthADDR  register address.
REQ-012 SHALL have port write_data_frame  in  g_WidthDATA  write data.
REQ-013 SHALL have port busy  out  1  command in progress.
REQ-014 SHALL have port read_data_frame  out  g_WidthDATA  read result.
REQ-015 SHALL have port Lane_Locked  out  g_NumberOfLanes  per-lane lock state.
REQ-016 SHALL have port Lane_Error  out  g_NumberOfLanes  one-cycle per-lane mismatch pulse.
REQ-017 SHALL have port Error_Flag  out  1  sticky OR of all lane errors.

Function
REQ-018 Expected pattern SHALL be a 16-bit incrementing count per lane: s1=s0+1, s2=s0+2, s3=s0+3, next word s0 = previous s3+1. Arithmetic is modulo 2^16; 0xFFFF -> 0x0000 is a valid step.
REQ-019 Each lane SHALL run a two-state FSM, UNLOCKED and LOCKED. Data is considered only on cycles with Data_Valid=1 and the check enabled.
REQ-020 UNLOCKED->LOCKED SHALL occur on a valid word whose four samples are internally consecutive. The expected value is then seeded to s3+1. A non-consecutive word keeps the lane UNLOCKED and does not count an error.
REQ-021 In LOCKED, a word equal to its expected value SHALL advance the expectation by 4 and clear the lane's consecutive-miss counter.
REQ-022 In LOCKED, a mismatching word SHALL:
- increment the lane error counter, saturating at 0xFFFF;
- pulse Lane_Error[n] for one cycle;
- set Error_Flag;
- re-seed the expectation to received s3+1;
- increment the 2-bit consecutive-miss counter.
REQ-023 The fourth consecutive mismatch SHALL return the lane to UNLOCKED.
REQ-024 Lane_Error and Lane_Locked SHALL be registered, updating on the cycle after the qualifying Data_Valid cycle (latency 1).
REQ-025 A 32-bit word counter SHALL increment on every enabled Data_Valid cycle and wrap at 2^32.
REQ-026 Register map:
- 0x00 CTRL: bit0 enable (R/W, reset 0); bit1 clear (write-1, self-clearing, reads 0).
- 0x01 STATUS: [g_NumberOfLanes-1:0] Lane_Locked, bit15 Error_Flag (RO).
- 0x02 word count [15:0] (RO); 0x03 word count [31:16] (RO).
- 0x10+n lane n error count (RO).
- Reads of unmapped addresses SHALL return 0x0000; writes to them are ignored.
REQ-027 Clear SHALL zero all error counters, the word counter and Error_Flag on the cycle after the write. Clear beats a simultaneous increment. Lock state is unaffected.
REQ-028 Enable=0 SHALL force all lanes to UNLOCKED and freeze all counters, which keep their values.
REQ-029 Handshake:
- enable_cmd=1 while busy=0 accepts a command; busy SHALL be 1 for exactly the two following cycles.
- A write takes effect in the first busy cycle.
- read_data_frame SHALL be loaded in the second busy cycle and held until the next read completes.
- enable_cmd while busy=1 SHALL be ignored.
REQ-030 Word-count reads SHALL be coherent: reading 0x02 snapshots the full 32 bits, and 0x03 returns the snapshot's high half.

Reset
REQ-031 Reset_N=0 at a clock edge SHALL set:
- busy=0, read_data_frame=0, Lane_Locked=0, Lane_Error=0, Error_Flag=0;
- enable=0, all counters 0, all lanes UNLOCKED;
- any in-flight command aborted.
REQ-032 After Reset_N returns high, the block SHALL accept a command on the next cycle.

Verification
REQ-033 Write 0x00=0x0001. Feed lane 0 words 0x0003_0002_0001_0000 then 0x0007_0006_0005_0004 -> Lane_Locked[0]=1 one cycle after the first word; no Lane_Error; read 0x10 = 0x0000.
REQ-034 Locked lane 2, feed a word with s0=0xFFFC then s0=0x0000 -> no error (wrap legal).
REQ-035 Locked lane 1, inject one corrupted word -> Lane_Error[1] one-cycle pulse; read 0x11 = 0x0001; Error_Flag=1; lane stays locked. Four consecutive corruptions -> Lane_Locked[1]=0.
REQ-036 Drive 0x10000 errors on lane 3 -> read 0x13 = 0xFFFF (saturated). Write 0x00=0x0003 -> 0x13 = 0x0000 and Error_Flag=0.
REQ-037 enable_cmd read of 0x01 with enable_cmd re-asserted during busy -> busy high exactly 2 cycles; the second command is ignored; read_data_frame = lock vector.
REQ-038 Reset_N=0 mid-command with lanes locked -> next cycle busy=0, Lane_Locked=0, all register reads return 0x0000.
